// File: rtl/axi_write_arbiter.sv
// Round-robin write-path arbiter for the 4-master AXI interconnect.
// Optional watchdog abort: define AXI_WR_ARB_TIMEOUT_EN.
module axi_write_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       s0_AWVALID,
  input  logic       s1_AWVALID,
  input  logic       s2_AWVALID,
  input  logic       s3_AWVALID,
  input  logic       s2m_AWVALID,
  input  logic       s2m_AWREADY,
  input  logic       s2m_WVALID,
  input  logic       s2m_WREADY,
  input  logic       s2m_WLAST,
  input  logic       s2m_BVALID,
  input  logic       s2m_BREADY,
  output logic       s0_wgrnt,
  output logic       s1_wgrnt,
  output logic       s2_wgrnt,
  output logic       s3_wgrnt,
  output logic       wr_busy,
  output logic       wr_timeout,
  output logic [1:0] wr_timeout_id
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ADDR_DATA = 2'd1,
    RESP      = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [NUM_MASTERS-1:0] req;
  logic [3:0] grnt, grnt_nxt;
  logic [1:0] last_grant, last_nxt, pick;
  logic       found;
  logic       aw_done, w_done, aw_nxt, w_nxt;
  logic       busy_q;
  logic       aw_hs, wl_hs, b_hs;
  logic       abort;

  assign req   = {s3_AWVALID, s2_AWVALID, s1_AWVALID, s0_AWVALID};
  assign aw_hs = s2m_AWVALID & s2m_AWREADY;
  assign wl_hs = s2m_WVALID & s2m_WREADY & s2m_WLAST;
  assign b_hs  = s2m_BVALID & s2m_BREADY;

  // Rotating search starting just after the previous owner.
  always_comb begin
    pick  = last_grant;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      if (!found && req[last_grant + 2'(i)]) begin
        found = 1'b1;
        pick  = last_grant + 2'(i);
      end
    end
  end

  // Next state, next grant and phase-completion flags.
  always_comb begin
    state_nxt = state;
    grnt_nxt  = grnt;
    last_nxt  = last_grant;
    aw_nxt    = aw_done;
    w_nxt     = w_done;
    unique case (state)
      IDLE: begin
        if (found) begin
          state_nxt = ADDR_DATA;
          grnt_nxt  = 4'b0001 << pick;
          last_nxt  = pick;
          aw_nxt    = 1'b0;
          w_nxt     = 1'b0;
        end
      end
      ADDR_DATA: begin
        aw_nxt = aw_done | aw_hs;
        w_nxt  = w_done | wl_hs;
        if (aw_nxt && w_nxt) begin
          state_nxt = RESP;
          aw_nxt    = 1'b0;
          w_nxt     = 1'b0;
        end
      end
      RESP: begin
        if (b_hs) begin
          state_nxt = IDLE;
          grnt_nxt  = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        grnt_nxt  = '0;
      end
    endcase
    if (abort) begin
      state_nxt = IDLE;
      grnt_nxt  = '0;
      aw_nxt    = 1'b0;
      w_nxt     = 1'b0;
    end
  end

  // Arbiter state registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      grnt       <= '0;
      last_grant <= 2'd3;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state      <= state_nxt;
      grnt       <= grnt_nxt;
      last_grant <= last_nxt;
      aw_done    <= aw_nxt;
      w_done     <= w_nxt;
      busy_q     <= (state_nxt != IDLE);
    end
  end

`ifdef AXI_WR_ARB_TIMEOUT_EN
  logic [15:0] wd_cnt;
  logic        any_hs;
  logic        to_q;
  logic [1:0]  to_id_q;

  assign any_hs = aw_hs | (s2m_WVALID & s2m_WREADY) | b_hs;
  assign abort  = (state != IDLE) && !any_hs &&
                  (wd_cnt == 16'(TIMEOUT_CYCLES - 1));

  // Watchdog: restarts on any handshake, idles at zero.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wd_cnt <= '0;
    end else if (state == IDLE || any_hs || abort) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 16'd1;
    end
  end

  // Abort pulse and sticky id of the aborted owner.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      to_q    <= 1'b0;
      to_id_q <= 2'd0;
    end else begin
      to_q <= abort;
      if (abort) to_id_q <= last_grant;
    end
  end

  assign wr_timeout    = to_q;
  assign wr_timeout_id = to_id_q;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

  assign abort         = 1'b0;
  assign wr_timeout    = 1'b0;
  assign wr_timeout_id = 2'd0;
`endif

  assign s0_wgrnt = grnt[0];
  assign s1_wgrnt = grnt[1];
  assign s2_wgrnt = grnt[2];
  assign s3_wgrnt = grnt[3];
  assign wr_busy  = busy_q;

endmodule
